// File: rtl/action_cfg_axil.sv
// rtl/action_cfg_axil.sv - AXI4-Lite slave bridging register accesses onto an action-table port
module action_cfg_axil #(
    parameter int TIMEOUT     = 16,
    parameter int NUM_ENTRIES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [15:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        tbl_we,
    output logic [15:0] tbl_waddr,
    output logic [31:0] tbl_wdata,
    input  logic        tbl_wdone,
    output logic        tbl_re,
    output logic [9:0]  tbl_raddr,
    input  logic [31:0] tbl_rdata,
    input  logic        tbl_rvalid
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;
    localparam logic [1:0]     RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

    function automatic logic out_of_range(input logic [15:2] a);
        return (a[15:12] != 4'h0) || (32'(a[11:2]) >= 32'(NUM_ENTRIES));
    endfunction

    // Byte-lane bits never select anything; entries are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

    logic          rst_done_q;
    wstate_t       wstate_q, wstate_d;
    rstate_t       rstate_q, rstate_d;
    logic          aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [15:2]   awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [15:0]   tbl_waddr_q, tbl_waddr_d;
    logic [31:0]   tbl_wdata_q, tbl_wdata_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          tbl_re_q, tbl_re_d;
    logic [9:0]    tbl_raddr_q, tbl_raddr_d;
    logic [CW-1:0] rcnt_q, rcnt_d;

    logic awready_w, wready_w, arready_w, aw_fire, w_fire, ar_fire;

    // Readies stay low until the first clock edge after reset release.
    assign awready_w = rst_done_q && (wstate_q == W_IDLE) && !aw_got_q;
    assign wready_w  = rst_done_q && (wstate_q == W_IDLE) && !w_got_q;
    assign arready_w = rst_done_q && (rstate_q == R_IDLE);
    assign aw_fire   = s_awvalid && awready_w;
    assign w_fire    = s_wvalid && wready_w;
    assign ar_fire   = s_arvalid && arready_w;

    always_comb begin
        wstate_d    = wstate_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        tbl_waddr_d = tbl_waddr_q;
        tbl_wdata_d = tbl_wdata_q;
        wcnt_d      = (wcnt_q == CNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
        case (wstate_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_got_d = 1'b1;
                    awaddr_d = s_awaddr[15:2];
                end
                if (w_fire) begin
                    w_got_d = 1'b1;
                    wdata_d = s_wdata;
                    wstrb_d = s_wstrb;
                end
                if (aw_got_d && w_got_d) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    if (out_of_range(awaddr_d)) begin
                        bresp_d  = RESP_DECERR;
                        wstate_d = W_RESP;
                    end else if (wstrb_d != 4'hF) begin
                        bresp_d  = RESP_SLVERR;
                        wstate_d = W_RESP;
                    end else begin
                        tbl_waddr_d = {6'b0, awaddr_d[11:2]};
                        tbl_wdata_d = wdata_d;
                        wstate_d    = W_EXEC;
                    end
                end
            end
            W_EXEC: begin
                wcnt_d   = '0;
                wstate_d = W_WAIT;
            end
            W_WAIT: begin
                if (tbl_wdone) begin
                    bresp_d  = RESP_OKAY;
                    wstate_d = W_RESP;
                end else if (wcnt_q == CNT_LAST) begin
                    bresp_d  = RESP_SLVERR;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d    = rstate_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        tbl_raddr_d = tbl_raddr_q;
        tbl_re_d    = 1'b0;
        rcnt_d      = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + 1'b1;
        case (rstate_q)
            R_IDLE: begin
                if (ar_fire) begin
                    if (out_of_range(s_araddr[15:2])) begin
                        rresp_d  = RESP_DECERR;
                        rdata_d  = '0;
                        rstate_d = R_RESP;
                    end else begin
                        tbl_re_d    = 1'b1;
                        tbl_raddr_d = s_araddr[11:2];
                        rcnt_d      = '0;
                        rstate_d    = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (tbl_rvalid) begin
                    rdata_d  = tbl_rdata;
                    rresp_d  = RESP_OKAY;
                    rstate_d = R_RESP;
                end else if (rcnt_q == CNT_LAST) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q  <= 1'b0;
            wstate_q    <= W_IDLE;
            rstate_q    <= R_IDLE;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bresp_q     <= '0;
            tbl_waddr_q <= '0;
            tbl_wdata_q <= '0;
            wcnt_q      <= '0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            tbl_re_q    <= 1'b0;
            tbl_raddr_q <= '0;
            rcnt_q      <= '0;
        end else begin
            rst_done_q  <= 1'b1;
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            aw_got_q    <= aw_got_d;
            w_got_q     <= w_got_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bresp_q     <= bresp_d;
            tbl_waddr_q <= tbl_waddr_d;
            tbl_wdata_q <= tbl_wdata_d;
            wcnt_q      <= wcnt_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            tbl_re_q    <= tbl_re_d;
            tbl_raddr_q <= tbl_raddr_d;
            rcnt_q      <= rcnt_d;
        end
    end

    assign s_awready = awready_w;
    assign s_wready  = wready_w;
    assign s_arready = arready_w;
    assign s_bvalid  = (wstate_q == W_RESP);
    assign s_bresp   = bresp_q;
    assign s_rvalid  = (rstate_q == R_RESP);
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign tbl_we    = (wstate_q == W_EXEC);
    assign tbl_waddr = tbl_waddr_q;
    assign tbl_wdata = tbl_wdata_q;
    assign tbl_re    = tbl_re_q;
    assign tbl_raddr = tbl_raddr_q;

endmodule

// File: tb/tb_action_cfg_axil.sv
// tb/tb_action_cfg_axil.sv - scoreboard bench for action_cfg_axil
module tb_action_cfg_axil;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [15:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic        tbl_we;
    logic [15:0] tbl_waddr;
    logic [31:0] tbl_wdata;
    logic        tbl_wdone;
    logic        tbl_re;
    logic [9:0]  tbl_raddr;
    logic [31:0] tbl_rdata;
    logic        tbl_rvalid;

    action_cfg_axil #(.TIMEOUT(TMO), .NUM_ENTRIES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata), .tbl_wdone(tbl_wdone),
        .tbl_re(tbl_re), .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata), .tbl_rvalid(tbl_rvalid)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int we_count = 0;
    int last_we_cyc = 0;
    int wdone_dly = 3;
    int rvalid_dly = 1;
    logic [31:0] rdata_val = 32'h0;

    logic [47:0] exp_we[$];
    logic [9:0]  exp_re[$];
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tbl_we) begin
                    we_count++;
                    last_we_cyc = cyc;
                    check("tbl_we_expected", 64'(exp_we.size() > 0), 64'd1);
                    if (exp_we.size() > 0)
                        check("tbl_waddr_wdata", {16'h0, tbl_waddr, tbl_wdata}, {16'h0, exp_we.pop_front()});
                end
                if (tbl_re) begin
                    check("tbl_re_expected", 64'(exp_re.size() > 0), 64'd1);
                    if (exp_re.size() > 0)
                        check("tbl_raddr", 64'(tbl_raddr), 64'(exp_re.pop_front()));
                end
                if (s_bvalid && s_bready) begin
                    check("b_expected", 64'(exp_b.size() > 0), 64'd1);
                    if (exp_b.size() > 0)
                        check("bresp", 64'(s_bresp), 64'(exp_b.pop_front()));
                end
                if (s_rvalid && s_rready) begin
                    check("r_expected", 64'(exp_r.size() > 0), 64'd1);
                    if (exp_r.size() > 0)
                        check("rresp_rdata", 64'({s_rresp, s_rdata}), 64'(exp_r.pop_front()));
                end
            end
        end
    end

    // Table model: answers each strobe after a programmable delay (negative = never).
    initial begin : wdone_model
        tbl_wdone = 1'b0;
        forever begin
            @(negedge clk);
            if (tbl_we && wdone_dly >= 0) begin
                repeat (wdone_dly) @(posedge clk);
                #1 tbl_wdone = 1'b1;
                @(posedge clk);
                #1 tbl_wdone = 1'b0;
            end
        end
    end

    initial begin : rvalid_model
        tbl_rvalid = 1'b0;
        tbl_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (tbl_re && rvalid_dly >= 0) begin
                repeat (rvalid_dly) @(posedge clk);
                #1 tbl_rvalid = 1'b1;
                tbl_rdata = rdata_val;
                @(posedge clk);
                #1 tbl_rvalid = 1'b0;
                tbl_rdata = 32'h0;
            end
        end
    end

    task automatic send_aw(input logic [15:0] a);
        bit ok = 0;
        s_awaddr = a;
        s_awvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_awready) begin ok = 1; break; end
        end
        check("aw_accepted", 64'(ok), 64'd1);
        @(posedge clk);
        #1 s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] strb);
        bit ok = 0;
        s_wdata = d;
        s_wstrb = strb;
        s_wvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_wready) begin ok = 1; break; end
        end
        check("w_accepted", 64'(ok), 64'd1);
        @(posedge clk);
        #1 s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] a);
        bit ok = 0;
        s_araddr = a;
        s_arvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_arready) begin ok = 1; break; end
        end
        check("ar_accepted", 64'(ok), 64'd1);
        @(posedge clk);
        #1 s_arvalid = 1'b0;
    endtask

    task automatic wait_b(output int at_cyc);
        bit seen = 0;
        at_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_bvalid) begin seen = 1; at_cyc = cyc; break; end
        end
        check("bvalid_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_r();
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_rvalid) begin seen = 1; break; end
        end
        check("rvalid_seen", 64'(seen), 64'd1);
    endtask

    // aw_lag: cycles the W beat leads the AW beat.
    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] strb,
                            input int aw_lag, input bit expect_we, input logic [1:0] resp);
        exp_b.push_back(resp);
        fork
            begin
                if (aw_lag > 0) begin
                    repeat (aw_lag) @(posedge clk);
                    #1;
                end
                if (expect_we) exp_we.push_back({6'b0, a[11:2], d});
                send_aw(a);
            end
            send_w(d, strb);
        join
    endtask

    task automatic do_read(input logic [15:0] a, input bit expect_re,
                           input logic [1:0] resp, input logic [31:0] d);
        exp_r.push_back({resp, d});
        if (expect_re) exp_re.push_back(a[11:2]);
        send_ar(a);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w0;
        int cb;
        int bv_hits;
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b1;
        s_araddr = '0; s_arvalid = 1'b0;
        s_rready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(s_awready), 64'd0);
        check("rst_wready", 64'(s_wready), 64'd0);
        check("rst_arready", 64'(s_arready), 64'd0);
        check("rst_valids", 64'({s_bvalid, s_rvalid, tbl_we, tbl_re}), 64'd0);
        check("rst_resp_data", 64'({s_bresp, s_rresp, s_rdata}), 64'd0);
        check("rst_tbl_data", {6'h0, tbl_raddr, tbl_waddr, tbl_wdata}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_readies", 64'({s_awready, s_wready, s_arready}), 64'h7);
        @(posedge clk);
        #1;

        // AW and W in the same cycle, wdone 3 cycles after tbl_we
        wdone_dly = 3;
        w0 = we_count;
        do_write(16'h0008, 32'hDEADBEEF, 4'hF, 0, 1'b1, 2'b00);
        wait_b(cb);
        @(posedge clk); #1;
        check("single_we_pulse", 64'(we_count - w0), 64'd1);

        // W leads AW by 5 cycles, top entry
        w0 = we_count;
        do_write(16'h0FFC, 32'hCAFEF00D, 4'hF, 5, 1'b1, 2'b00);
        wait_b(cb);
        @(posedge clk); #1;
        check("late_aw_we_pulse", 64'(we_count - w0), 64'd1);

        // Error responses never touch the table
        w0 = we_count;
        do_write(16'h1000, 32'h11111111, 4'hF, 0, 1'b0, 2'b11);
        wait_b(cb);
        @(posedge clk); #1;
        do_write(16'h0004, 32'h22222222, 4'h3, 0, 1'b0, 2'b10);
        wait_b(cb);
        @(posedge clk); #1;
        check("err_no_we", 64'(we_count - w0), 64'd0);

        // Write timeout with back-pressured B channel
        wdone_dly = -1;
        s_bready = 1'b0;
        do_write(16'h0020, 32'h0BADF00D, 4'hF, 0, 1'b1, 2'b10);
        wait_b(cb);
        check("w_timeout_latency", 64'(cb - last_we_cyc), 64'(TMO + 1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_hold", 64'({s_bvalid, s_bresp}), 64'h6);
        end
        @(posedge clk);
        #1 s_bready = 1'b1;
        @(posedge clk); #1;

        // Concurrent read and write, read answered the next cycle
        wdone_dly = 2;
        rvalid_dly = 1;
        rdata_val = 32'h0000_1234;
        fork
            begin
                do_write(16'h0030, 32'h55AA55AA, 4'hF, 0, 1'b1, 2'b00);
                wait_b(cb);
            end
            begin
                do_read(16'h0010, 1'b1, 2'b00, 32'h0000_1234);
                wait_r();
            end
        join
        @(posedge clk); #1;

        // Out-of-range read and read timeout
        do_read(16'h2000, 1'b0, 2'b11, 32'h0);
        wait_r();
        @(posedge clk); #1;
        rvalid_dly = -1;
        rdata_val = 32'hFFFF_FFFF;
        do_read(16'h0040, 1'b1, 2'b10, 32'h0);
        wait_r();
        @(posedge clk); #1;

        // Reset while waiting for tbl_wdone
        wdone_dly = -1;
        w0 = we_count;
        do_write(16'h0044, 32'h77777777, 4'hF, 0, 1'b1, 2'b10);
        for (int i = 0; i < 20 && we_count == w0; i++) @(negedge clk);
        check("mid_rst_we_seen", 64'(we_count - w0), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_outputs", 64'({s_bvalid, s_awready, s_wready, tbl_we}), 64'd0);
        exp_b.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bv_hits = 0;
        w0 = we_count;
        for (int i = 0; i < TMO + 4; i++) begin
            @(negedge clk);
            if (s_bvalid) bv_hits++;
        end
        check("post_rst_no_bvalid", 64'(bv_hits), 64'd0);
        check("post_rst_no_we", 64'(we_count - w0), 64'd0);
        check("post_rst_idle", 64'({s_awready, s_wready, s_arready}), 64'h7);
        @(posedge clk); #1;
        wdone_dly = 1;
        do_write(16'h0048, 32'h89ABCDEF, 4'hF, 0, 1'b1, 2'b00);
        wait_b(cb);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);

        check("we_queue_drained", 64'(exp_we.size()), 64'd0);
        check("re_queue_drained", 64'(exp_re.size()), 64'd0);
        check("b_queue_drained", 64'(exp_b.size()), 64'd0);
        check("r_queue_drained", 64'(exp_r.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
